// File: rtl/trashbin_core_sequencer.sv
// Multi-cycle control sequencer for the Trashbin core: instruction fetch, load/store
// bus transactions with a per-transaction timeout, and register/PC commit.
module trashbin_core_sequencer #(
    parameter int unsigned           ADDR_WIDTH     = 32,
    parameter int unsigned           DATA_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR   = '0,
    parameter bit                    WORD_ADDRESSED = 1'b1,
    parameter int unsigned           WAIT_TIMEOUT   = 255
) (
    input  logic                  CoreClock,
    input  logic                  CoreResetN,
    output logic [ADDR_WIDTH-1:0] AddressBus,
    output logic                  ReadAssert,
    output logic                  WriteAssert,
    input  logic [DATA_WIDTH-1:0] DataReadBus,
    output logic [DATA_WIDTH-1:0] DataWriteBus,
    input  logic                  ReadOK,
    input  logic                  WriteOK,
    input  logic                  DecWritesRegisterFile,
    input  logic                  DecReadsRam,
    input  logic                  DecWritesRam,
    input  logic                  DecIsBranch,
    input  logic                  DecInvalid,
    input  logic                  BranchTaken,
    input  logic [ADDR_WIDTH-1:0] BranchTarget,
    input  logic [ADDR_WIDTH-1:0] MemAddress,
    input  logic [DATA_WIDTH-1:0] StoreData,
    output logic [DATA_WIDTH-1:0] CurrentInstruction,
    output logic [ADDR_WIDTH-1:0] ProgramCounter,
    output logic [ADDR_WIDTH-1:0] LinkAddress,
    output logic [DATA_WIDTH-1:0] LoadData,
    output logic                  RegisterWriteEnable,
    output logic                  RegisterWriteSelectMem,
    output logic                  Fault,
    output logic [1:0]            FaultCode,
    output logic [2:0]            Phase,
    output logic [31:0]           InstructionsRetired
);

    localparam int unsigned TimeoutWidth = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
    localparam logic [TimeoutWidth-1:0] TimeoutLast = TimeoutWidth'(WAIT_TIMEOUT - 1);

    localparam logic [1:0] FaultInvalid    = 2'b01;
    localparam logic [1:0] FaultTimeout    = 2'b10;
    localparam logic [1:0] FaultMisaligned = 2'b11;

    typedef enum logic [2:0] {
        PhFetch     = 3'd0,
        PhFetchWait = 3'd1,
        PhExec      = 3'd2,
        PhMemRead   = 3'd3,
        PhMemWrite  = 3'd4,
        PhWriteback = 3'd5,
        PhFault     = 3'd6
    } phaseT;

    phaseT                   state;
    phaseT                   stateNext;
    logic [ADDR_WIDTH-1:0]   pcNext;
    logic [DATA_WIDTH-1:0]   instrNext;
    logic [DATA_WIDTH-1:0]   loadNext;
    logic [31:0]             retiredNext;
    logic                    faultNext;
    logic [1:0]              faultCodeNext;
    logic [TimeoutWidth-1:0] waitCount;
    logic [TimeoutWidth-1:0] waitCountNext;
    logic                    readC;
    logic                    writeC;
    logic                    commitC;
    logic                    memAddrSel;
    logic                    timeoutHit;
    logic                    takenBranch;
    logic                    memAccess;
    logic [ADDR_WIDTH-1:0]   busByteAddr;

    assign timeoutHit  = (waitCount == TimeoutLast);
    assign takenBranch = DecIsBranch & BranchTaken;
    assign memAccess   = DecReadsRam | DecWritesRam;

    // State and architectural registers
    always_ff @(posedge CoreClock) begin
        if (!CoreResetN) begin
            state               <= PhFetch;
            ProgramCounter      <= RESET_VECTOR;
            CurrentInstruction  <= '0;
            LoadData            <= '0;
            InstructionsRetired <= '0;
            Fault               <= 1'b0;
            FaultCode           <= 2'b00;
            waitCount           <= '0;
        end else begin
            state               <= stateNext;
            ProgramCounter      <= pcNext;
            CurrentInstruction  <= instrNext;
            LoadData            <= loadNext;
            InstructionsRetired <= retiredNext;
            Fault               <= faultNext;
            FaultCode           <= faultCodeNext;
            waitCount           <= waitCountNext;
        end
    end

    // Next-state, commit and strobe decode; waitCount clears on every transition
    always_comb begin
        stateNext     = state;
        pcNext        = ProgramCounter;
        instrNext     = CurrentInstruction;
        loadNext      = LoadData;
        retiredNext   = InstructionsRetired;
        faultNext     = Fault;
        faultCodeNext = FaultCode;
        waitCountNext = '0;
        readC         = 1'b0;
        writeC        = 1'b0;
        commitC       = 1'b0;
        memAddrSel    = 1'b0;

        case (state)
            PhFetch: begin
                readC = 1'b1;
                if (ProgramCounter[1:0] != 2'b00) begin
                    stateNext     = PhFault;
                    faultNext     = 1'b1;
                    faultCodeNext = FaultMisaligned;
                end else begin
                    stateNext = PhFetchWait;
                end
            end
            PhFetchWait: begin
                readC = 1'b1;
                if (ReadOK) begin
                    instrNext = DataReadBus;
                    stateNext = PhExec;
                end else if (timeoutHit) begin
                    stateNext     = PhFault;
                    faultNext     = 1'b1;
                    faultCodeNext = FaultTimeout;
                end else begin
                    waitCountNext = waitCount + TimeoutWidth'(1);
                end
            end
            PhExec: begin
                if (DecInvalid || (DecReadsRam && DecWritesRam)) begin
                    stateNext     = PhFault;
                    faultNext     = 1'b1;
                    faultCodeNext = FaultInvalid;
                end else if ((memAccess && (MemAddress[1:0] != 2'b00)) ||
                             (takenBranch && (BranchTarget[1:0] != 2'b00))) begin
                    stateNext     = PhFault;
                    faultNext     = 1'b1;
                    faultCodeNext = FaultMisaligned;
                end else if (DecReadsRam) begin
                    stateNext = PhMemRead;
                end else if (DecWritesRam) begin
                    stateNext = PhMemWrite;
                end else begin
                    stateNext = PhWriteback;
                end
            end
            PhMemRead: begin
                readC      = 1'b1;
                memAddrSel = 1'b1;
                if (ReadOK) begin
                    loadNext  = DataReadBus;
                    stateNext = PhWriteback;
                end else if (timeoutHit) begin
                    stateNext     = PhFault;
                    faultNext     = 1'b1;
                    faultCodeNext = FaultTimeout;
                end else begin
                    waitCountNext = waitCount + TimeoutWidth'(1);
                end
            end
            PhMemWrite: begin
                writeC     = 1'b1;
                memAddrSel = 1'b1;
                if (WriteOK) begin
                    stateNext = PhWriteback;
                end else if (timeoutHit) begin
                    stateNext     = PhFault;
                    faultNext     = 1'b1;
                    faultCodeNext = FaultTimeout;
                end else begin
                    waitCountNext = waitCount + TimeoutWidth'(1);
                end
            end
            PhWriteback: begin
                commitC     = DecWritesRegisterFile;
                pcNext      = takenBranch ? BranchTarget : ProgramCounter + ADDR_WIDTH'(4);
                retiredNext = InstructionsRetired + 32'd1;
                stateNext   = PhFetch;
            end
            default: ;
        endcase
    end

    // Strobes are forced low for the whole time reset is held
    assign ReadAssert             = readC & CoreResetN;
    assign WriteAssert            = writeC & CoreResetN;
    assign RegisterWriteEnable    = commitC & CoreResetN;
    assign RegisterWriteSelectMem = DecReadsRam;
    assign DataWriteBus           = StoreData;
    assign LinkAddress            = ProgramCounter + ADDR_WIDTH'(4);
    assign Phase                  = state;

    assign busByteAddr = memAddrSel ? MemAddress : ProgramCounter;
    assign AddressBus  = WORD_ADDRESSED ? (busByteAddr >> 2) : busByteAddr;

endmodule

// File: tb/tb_trashbin_core_sequencer.sv
// Directed bench for trashbin_core_sequencer: bus responder model, commit scoreboard
// checked at each writeback, and per-instruction timing/fault checks.
module tb_trashbin_core_sequencer;

    typedef struct packed {
        logic        we;
        logic        selMem;
        logic [31:0] loadData;
    } commitT;

    logic        CoreClock = 1'b0;
    logic        CoreResetN;
    logic [31:0] AddressBus;
    logic        ReadAssert;
    logic        WriteAssert;
    logic [31:0] DataReadBus = '0;
    logic [31:0] DataWriteBus;
    logic        ReadOK = 1'b0;
    logic        WriteOK = 1'b0;
    logic        DecWritesRegisterFile;
    logic        DecReadsRam;
    logic        DecWritesRam;
    logic        DecIsBranch;
    logic        DecInvalid;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic [31:0] MemAddress;
    logic [31:0] StoreData;
    logic [31:0] CurrentInstruction;
    logic [31:0] ProgramCounter;
    logic [31:0] LinkAddress;
    logic [31:0] LoadData;
    logic        RegisterWriteEnable;
    logic        RegisterWriteSelectMem;
    logic        Fault;
    logic [1:0]  FaultCode;
    logic [2:0]  Phase;
    logic [31:0] InstructionsRetired;

    int compared = 0;
    int mismatched = 0;

    // Responder configuration, changed only while the DUT sits in FETCH
    int          fetchDelay = 0;
    int          memDelay = 0;
    logic        noResponse = 1'b0;
    logic [31:0] instrWord = '0;
    logic [31:0] loadWord = '0;
    int          waitCtr = 0;
    int          delayNow = 0;

    // Observations gathered over one instruction
    int          obsCycles;
    int          obsWe;
    int          obsRd;
    int          obsWr;
    logic [31:0] obsMemAddr;
    logic [31:0] obsMemData;
    logic [31:0] obsFetchAddr;
    logic        obsFetchRead;

    commitT sbQueue[$];
    commitT sbExp;

    trashbin_core_sequencer #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .RESET_VECTOR  (32'h0000_0100),
        .WORD_ADDRESSED(1'b1),
        .WAIT_TIMEOUT  (4)
    ) dut (
        .CoreClock             (CoreClock),
        .CoreResetN            (CoreResetN),
        .AddressBus            (AddressBus),
        .ReadAssert            (ReadAssert),
        .WriteAssert           (WriteAssert),
        .DataReadBus           (DataReadBus),
        .DataWriteBus          (DataWriteBus),
        .ReadOK                (ReadOK),
        .WriteOK               (WriteOK),
        .DecWritesRegisterFile (DecWritesRegisterFile),
        .DecReadsRam           (DecReadsRam),
        .DecWritesRam          (DecWritesRam),
        .DecIsBranch           (DecIsBranch),
        .DecInvalid            (DecInvalid),
        .BranchTaken           (BranchTaken),
        .BranchTarget          (BranchTarget),
        .MemAddress            (MemAddress),
        .StoreData             (StoreData),
        .CurrentInstruction    (CurrentInstruction),
        .ProgramCounter        (ProgramCounter),
        .LinkAddress           (LinkAddress),
        .LoadData              (LoadData),
        .RegisterWriteEnable   (RegisterWriteEnable),
        .RegisterWriteSelectMem(RegisterWriteSelectMem),
        .Fault                 (Fault),
        .FaultCode             (FaultCode),
        .Phase                 (Phase),
        .InstructionsRetired   (InstructionsRetired)
    );

    always #5 CoreClock = ~CoreClock;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    // Memory responder: OK after a programmed number of wait cycles in a wait state
    always @(negedge CoreClock) begin
        if (Phase == 3'd1 || Phase == 3'd3 || Phase == 3'd4) begin
            delayNow    = (Phase == 3'd1) ? fetchDelay : memDelay;
            DataReadBus = (Phase == 3'd1) ? instrWord : loadWord;
            ReadOK      = !noResponse && (waitCtr == delayNow) && (Phase != 3'd4);
            WriteOK     = !noResponse && (waitCtr == delayNow) && (Phase == 3'd4);
            waitCtr     = waitCtr + 1;
        end else begin
            waitCtr = 0;
            ReadOK  = 1'b0;
            WriteOK = 1'b0;
        end
    end

    // Commit scoreboard: one expected record per writeback
    always @(negedge CoreClock) begin
        if (CoreResetN === 1'b1 && Phase == 3'd5) begin
            compared++;
            if (sbQueue.size() == 0) begin
                mismatched++;
                $error("FAIL sb_empty: observed writeback expected none");
            end else begin
                sbExp = sbQueue.pop_front();
                assert ({RegisterWriteEnable, RegisterWriteSelectMem, LoadData} === sbExp)
                else begin
                    mismatched++;
                    $error("FAIL sb_commit: observed 0x%0h expected 0x%0h",
                           {RegisterWriteEnable, RegisterWriteSelectMem, LoadData}, sbExp);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic setDec(input logic we, input logic rd, input logic wr,
                          input logic br, input logic tk, input logic inv);
        DecWritesRegisterFile = we;
        DecReadsRam           = rd;
        DecWritesRam          = wr;
        DecIsBranch           = br;
        BranchTaken           = tk;
        DecInvalid            = inv;
    endtask

    // Called at a negedge in FETCH; runs until the next FETCH or FAULT (bounded)
    task automatic runInstr();
        #1;
        obsFetchAddr = AddressBus;
        obsFetchRead = ReadAssert;
        obsCycles    = 1;
        obsWe        = 0;
        obsRd        = 0;
        obsWr        = 0;
        obsMemAddr   = '0;
        obsMemData   = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CoreClock);
            if (Phase == 3'd0 || Phase == 3'd6) break;
            obsCycles++;
            if (RegisterWriteEnable) obsWe++;
            if (Phase == 3'd3 && ReadAssert) begin
                obsRd++;
                obsMemAddr = AddressBus;
            end
            if (Phase == 3'd4 && WriteAssert) begin
                obsWr++;
                obsMemAddr = AddressBus;
                obsMemData = DataWriteBus;
            end
        end
    endtask

    task automatic checkReset(input string tag);
        check({tag, "_pc"}, 64'(ProgramCounter), 64'h100);
        check({tag, "_phase"}, 64'(Phase), 64'd0);
        check({tag, "_retired"}, 64'(InstructionsRetired), 64'd0);
        check({tag, "_fault"}, 64'(Fault), 64'd0);
        check({tag, "_faultcode"}, 64'(FaultCode), 64'd0);
        check({tag, "_read"}, 64'(ReadAssert), 64'd0);
        check({tag, "_write"}, 64'(WriteAssert), 64'd0);
        check({tag, "_regwe"}, 64'(RegisterWriteEnable), 64'd0);
        check({tag, "_instr"}, 64'(CurrentInstruction), 64'd0);
        check({tag, "_load"}, 64'(LoadData), 64'd0);
    endtask

    initial begin
        CoreResetN   = 1'b0;
        BranchTarget = '0;
        MemAddress   = '0;
        StoreData    = '0;
        setDec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge CoreClock);
        checkReset("rst1");
        CoreResetN = 1'b1;

        // ADDI with register write, zero-wait fetch
        instrWord = 32'h0050_0093;
        setDec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        sbQueue.push_back({1'b1, 1'b0, 32'h0});
        runInstr();
        check("addi_fetch_addr", 64'(obsFetchAddr), 64'h40);
        check("addi_fetch_read", 64'(obsFetchRead), 64'd1);
        check("addi_cycles", 64'(obsCycles), 64'd4);
        check("addi_we_pulses", 64'(obsWe), 64'd1);
        check("addi_pc", 64'(ProgramCounter), 64'h104);
        check("addi_retired", 64'(InstructionsRetired), 64'd1);
        check("addi_instr", 64'(CurrentInstruction), 64'h0050_0093);
        check("addi_link", 64'(LinkAddress), 64'h108);

        // Load, read data returned after 3 wait cycles
        instrWord  = 32'h0000_2103;
        loadWord   = 32'hCAFE_F00D;
        MemAddress = 32'h0000_2000;
        memDelay   = 3;
        setDec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        sbQueue.push_back({1'b1, 1'b1, 32'hCAFE_F00D});
        runInstr();
        check("load_cycles", 64'(obsCycles), 64'd8);
        check("load_read_cycles", 64'(obsRd), 64'd4);
        check("load_addr", 64'(obsMemAddr), 64'h800);
        check("load_we_pulses", 64'(obsWe), 64'd1);
        check("load_data", 64'(LoadData), 64'hCAFE_F00D);
        check("load_pc", 64'(ProgramCounter), 64'h108);
        check("load_retired", 64'(InstructionsRetired), 64'd2);

        // Store, WriteOK after 2 wait cycles
        instrWord  = 32'h0020_2023;
        MemAddress = 32'h0000_3000;
        StoreData  = 32'hDEAD_BEEF;
        memDelay   = 2;
        setDec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        sbQueue.push_back({1'b0, 1'b0, 32'hCAFE_F00D});
        runInstr();
        check("store_fetch_addr", 64'(obsFetchAddr), 64'h42);
        check("store_cycles", 64'(obsCycles), 64'd7);
        check("store_write_cycles", 64'(obsWr), 64'd3);
        check("store_addr", 64'(obsMemAddr), 64'hC00);
        check("store_data", 64'(obsMemData), 64'hDEAD_BEEF);
        check("store_we_pulses", 64'(obsWe), 64'd0);
        check("store_pc", 64'(ProgramCounter), 64'h10C);
        check("store_idle_write", 64'(WriteAssert), 64'd0);
        check("store_idle_data", 64'(DataWriteBus), 64'hDEAD_BEEF);

        // Taken branch to 0x40 with one fetch wait cycle
        instrWord    = 32'h0000_0063;
        BranchTarget = 32'h0000_0040;
        fetchDelay   = 1;
        setDec(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        sbQueue.push_back({1'b0, 1'b0, 32'hCAFE_F00D});
        runInstr();
        check("br_taken_fetch_addr", 64'(obsFetchAddr), 64'h43);
        check("br_taken_cycles", 64'(obsCycles), 64'd5);
        check("br_taken_pc", 64'(ProgramCounter), 64'h40);
        check("br_taken_retired", 64'(InstructionsRetired), 64'd4);

        // Not-taken branch falls through
        BranchTarget = 32'h0000_0080;
        fetchDelay   = 0;
        setDec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        sbQueue.push_back({1'b0, 1'b0, 32'hCAFE_F00D});
        runInstr();
        check("br_fall_fetch_addr", 64'(obsFetchAddr), 64'h10);
        check("br_fall_cycles", 64'(obsCycles), 64'd4);
        check("br_fall_pc", 64'(ProgramCounter), 64'h44);
        check("br_fall_retired", 64'(InstructionsRetired), 64'd5);

        // Fetch never acknowledged: timeout after 4 wait cycles, then held
        noResponse = 1'b1;
        setDec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        runInstr();
        check("tmo_fetch_addr", 64'(obsFetchAddr), 64'h11);
        check("tmo_cycles", 64'(obsCycles), 64'd5);
        check("tmo_phase", 64'(Phase), 64'd6);
        check("tmo_fault", 64'(Fault), 64'd1);
        check("tmo_code", 64'(FaultCode), 64'd2);
        noResponse = 1'b0;
        repeat (6) @(negedge CoreClock);
        check("tmo_hold_phase", 64'(Phase), 64'd6);
        check("tmo_hold_fault", 64'(Fault), 64'd1);
        check("tmo_hold_code", 64'(FaultCode), 64'd2);
        check("tmo_hold_pc", 64'(ProgramCounter), 64'h44);
        check("tmo_hold_read", 64'(ReadAssert), 64'd0);
        check("tmo_hold_retired", 64'(InstructionsRetired), 64'd5);

        CoreResetN = 1'b0;
        repeat (2) @(negedge CoreClock);
        checkReset("rst2");
        CoreResetN = 1'b1;

        // Invalid instruction
        instrWord = 32'hFFFF_FFFF;
        setDec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        runInstr();
        check("inv_cycles", 64'(obsCycles), 64'd3);
        check("inv_phase", 64'(Phase), 64'd6);
        check("inv_code", 64'(FaultCode), 64'd1);
        check("inv_pc", 64'(ProgramCounter), 64'h100);

        CoreResetN = 1'b0;
        repeat (2) @(negedge CoreClock);
        checkReset("rst3");
        CoreResetN = 1'b1;

        // Misaligned load address never reaches MEM_READ
        instrWord  = 32'h0000_2103;
        MemAddress = 32'h0000_1002;
        setDec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        runInstr();
        check("mis_cycles", 64'(obsCycles), 64'd3);
        check("mis_read_cycles", 64'(obsRd), 64'd0);
        check("mis_fault", 64'(Fault), 64'd1);
        check("mis_code", 64'(FaultCode), 64'd3);
        check("mis_read", 64'(ReadAssert), 64'd0);

        check("sb_drained", 64'(sbQueue.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/trashbin_core_sequencer.md
# trashbin_core_sequencer

Parametrised multi-cycle control sequencer for the Trashbin core. It replaces the fixed five-phase counter with a state machine that:
- fetches instructions, issues load and store bus transactions, and commits register writes and PC updates;
- applies per-transaction bus timeouts and raises a sticky fault.

It sits between the memory bus and the existing decoder/ALU/register-file datapath. It consumes decoder control bits and ALU-computed addresses, and produces all bus strobes and commit enables.

## Interface
- ADDR_WIDTH, 32, width of PC and address bus
- DATA_WIDTH, 32, width of data buses and instruction register
- RESET_VECTOR, 0, PC value after reset
- WORD_ADDRESSED, 1, 1: AddressBus = address>>2; 0: AddressBus = byte address
- WAIT_TIMEOUT, 255, maximum cycles spent waiting for ReadOK/WriteOK before a fault; must be ≥1

Ports:
- CoreClock  in  1  core clock; all logic on rising edge
- CoreResetN  in  1  reset, synchronous, active-low
- AddressBus  out  ADDR_WIDTH  memory address
- ReadAssert  out  1  read request
- WriteAssert  out  1  write request
- DataReadBus  in  DATA_WIDTH  memory read data
- DataWriteBus  out  DATA_WIDTH  memory write data
- ReadOK  in  1  read complete; DataReadBus valid this cycle
- WriteOK  in  1  write accepted
- DecWritesRegisterFile, DecReadsRam, DecWritesRam, DecIsBranch, DecInvalid  in  1 each  decoder controls for CurrentInstruction
- BranchTaken  in  1  branch condition true
- BranchTarget  in  ADDR_WIDTH  byte target address
- MemAddress  in  ADDR_WIDTH  byte load/store address from ALU
- StoreData  in  DATA_WIDTH  store value (register port B)
- CurrentInstruction  out  DATA_WIDTH  latched instruction word
- ProgramCounter  out  ADDR_WIDTH  byte PC
- LinkAddress  out  ADDR_WIDTH  ProgramCounter+4, combinational
- LoadData  out  DATA_WIDTH  latched load result
- RegisterWriteEnable  out  1  commit strobe to register file
- RegisterWriteSelectMem  out  1  1: write LoadData; 0: write ALU result (= DecReadsRam)
- Fault  out  1  sticky fault flag
- FaultCode  out  2  01 invalid instruction, 10 bus timeout, 11 misaligned address
- Phase  out  3  current state encoding (debug)
- InstructionsRetired  out  32  commit counter

## Operation

States and encodings: FETCH=0, FETCH_WAIT=1, EXEC=2, MEM_READ=3, MEM_WRITE=4, WRITEBACK=5, FAULT=6.

- **FETCH:** AddressBus from PC, ReadAssert=1. Misaligned PC (PC[1:0]≠0) → FAULT/11. Otherwise → FETCH_WAIT.
- **FETCH_WAIT:** ReadAssert=1, AddressBus from PC.
  - On ReadOK: latch DataReadBus into CurrentInstruction → EXEC.
- **EXEC:** decoder outputs valid. Checks in priority order:
  1. DecInvalid, or DecReadsRam & DecWritesRam → FAULT/01.
  2. Load/store with MemAddress[1:0]≠0, or taken branch with BranchTarget[1:0]≠0 → FAULT/11.
  3. Otherwise: DecReadsRam → MEM_READ; DecWritesRam → MEM_WRITE; else → WRITEBACK.
- **MEM_READ:** AddressBus from MemAddress, ReadAssert=1.
  - On ReadOK: latch LoadData → WRITEBACK.
- **MEM_WRITE:** AddressBus from MemAddress, DataWriteBus=StoreData, WriteAssert=1.
  - On WriteOK → WRITEBACK.
- **WRITEBACK:**
  - RegisterWriteEnable = DecWritesRegisterFile.
  - PC ← BranchTarget if DecIsBranch & BranchTaken, else PC+4.
  - InstructionsRetired +1.
  - → FETCH.
- **FAULT:** all strobes 0; PC, Fault and FaultCode held until reset.

Rules:
- Timeout counter clears on every state entry and counts each cycle in a wait state without OK. Reaching WAIT_TIMEOUT → FAULT/10.
- The address shift applies only when WORD_ADDRESSED=1.
- PC arithmetic wraps modulo 2^ADDR_WIDTH.
- InstructionsRetired wraps at 2^32.
- Outside MEM_WRITE, DataWriteBus holds StoreData and WriteAssert=0.

## Timing
- Reset values while CoreResetN=0:
  - state FETCH, PC=RESET_VECTOR;
  - CurrentInstruction, LoadData, InstructionsRetired all 0;
  - Fault=0, FaultCode=00;
  - ReadAssert, WriteAssert and RegisterWriteEnable forced 0.
- Reset asserted mid-transaction abandons it; the first cycle after release is FETCH.
- ALU or branch instruction with zero-wait memory (ReadOK on the first FETCH_WAIT cycle): 4 cycles. Load/store: 5 cycles. Each wait cycle adds 1.
- OK asserted on the same cycle the timeout count is reached: OK wins.
- ReadOK/WriteOK are ignored outside their wait states.
- RegisterWriteEnable is high for exactly one cycle per committed instruction.

## Test plan
- Reset, RESET_VECTOR=0x100, zero-wait memory, ADDI with write → AddressBus=0x40 in FETCH, RegisterWriteEnable pulses at cycle 4, PC=0x104, InstructionsRetired=1.
- Load with MemAddress=0x2000 and ReadOK delayed 3 cycles → AddressBus=0x800 in MEM_READ, LoadData latched, RegisterWriteSelectMem=1, total 8 cycles.
- Store, StoreData=0xDEADBEEF → WriteAssert high until WriteOK, DataWriteBus=0xDEADBEEF, RegisterWriteEnable=0.
- Taken branch to 0x40, then not-taken branch → PC=0x40, then PC=0x44.
- Timeouts:
  - ReadOK never asserted, WAIT_TIMEOUT=4 → Fault=1, FaultCode=10 after 4 wait cycles, then held.
  - Reset releases the fault and PC=RESET_VECTOR.
- DecInvalid → FAULT/01. MemAddress=0x1002 on a load → FAULT/11, no ReadAssert in MEM_READ.
